hex_display_sequencer: RTL and testbench
========================================

// Module: hex_display_sequencer
// PURPOSE
//  Shares one combinational 4-bit hex-to-7-segment decoder (active-low segs, {g,f,e,d,c,b,a})
//  across NUM_DIGITS displays. Accepts an ULA/RPN result word by valid/ready handshake and scans
//  it one nibble per cycle through the decoder. Captures each segment word, then commits all digits
//  atomically. Adds leading-zero suppression, per-digit blanking and per-digit blinking.
// PARAMETERS
//  NUM_DIGITS   4           digits driven; value width = 4*NUM_DIGITS
//  BLINK_DIV    25000000    clk cycles per blink half-period (>=2)
//  LZ_SUPPRESS  1           1: blank leading zero digits (digit 0 never suppressed)
// PORTS
//  clk            in   1             system clock
//  rst            in   1             synchronous, active-high reset
//  upd_valid      in   1             new display request
//  upd_ready      out  1             sequencer can accept a request
//  upd_value      in   4*NUM_DIGITS  nibble k = digit k (digit 0 = rightmost)
//  upd_blank_mask in   NUM_DIGITS    1 = force digit dark
//  upd_blink_mask in   NUM_DIGITS    1 = digit blinks
//  dec_nibble     out  4             to shared decoder inputs A,B,C,D (A = MSB)
//  dec_seg        in   7             from shared decoder, same cycle (combinational)
//  hex_out        out  7*NUM_DIGITS  digit k on [7k+6:7k], active-low
//  busy           out  1             scan/commit in progress
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//  - Goes to IDLE. hex_out = all ones (dark). busy=0. dec_nibble=0.
//  - Blink counter and phase cleared to 0. Shadow and masks cleared.
//  - upd_ready=0 while rst=1.
//  Handshake
//  - upd_ready = (state==IDLE).
//  - A request is accepted on a posedge with upd_valid & upd_ready.
//  - At acceptance, value and masks are latched and the sequencer enters SCAN with idx=0.
//  - While ready=0, inputs are ignored; valid may be held.
//  FSM
//  - IDLE -> SCAN on accept.
//  - SCAN: dec_nibble = latched nibble[idx]; dec_seg is captured into shadow[idx] at the posedge.
//    idx increments; after idx==NUM_DIGITS-1 -> COMMIT.
//  - COMMIT: one cycle; visible <= shadow with suppression/blank applied; then -> IDLE.
//  - busy=1 in SCAN and COMMIT.
//  - Accept -> hex_out change latency: NUM_DIGITS+2 posedges (scan + commit + output register).
//  - Next request is accepted at the earliest one cycle after COMMIT.
//  Digit masking (computed at COMMIT)
//  - Blank if blank_mask[k] is set.
//  - Blank if LZ_SUPPRESS, k>0, and all nibbles k..NUM_DIGITS-1 are zero.
//  - Blank digit = 7'h7F. Value 0 therefore shows only digit 0 = 7'h40.
//  Blink
//  - Free-running counter 0..BLINK_DIV-1; phase toggles on wrap.
//  - Runs in every state; not reset by requests.
//  - hex_out is registered each cycle: hex_out[k] = (phase & blink_mask_vis[k]) ? 7'h7F : visible[k].
//  - blink_mask_vis updates only at COMMIT.
//  Edge cases
//  - rst during SCAN/COMMIT: abort, discard shadow, apply reset values; no partial commit.
//  - dec_nibble holds its last value in IDLE.
// TESTING (NUM_DIGITS=4, BLINK_DIV=4, LZ_SUPPRESS=1)
//  1 Reset 2 cycles -> hex_out=28'hFFFFFFF, busy=0; upd_ready=1 the first cycle after rst falls.
//  2 value=16'h12AF, masks=0 -> after 6 posedges hex_out = {7'h79,7'h24,7'h08,7'h0E};
//    dec_nibble sequence F,A,2,1.
//  3 value=16'h0005 -> {7F,7F,7F,7'h12}; value=16'h0000 -> {7F,7F,7F,7'h40}; value=16'h1000 -> {79,40,40,40}.
//  4 Hold upd_valid with 16'h12AF then 16'h0005 back-to-back -> second accepted only after first COMMIT;
//    ready=0 throughout busy; final display matches 16'h0005.
//  5 blink_mask=4'b0001, value=16'h12AF -> digit 0 alternates 7'h0E / 7'h7F every 4 cycles;
//    digits 3..1 steady.
//  6 Assert rst on 2nd SCAN cycle -> next cycle hex_out all 7F, busy=0; following request displays correctly.

Source files
------------

// File: rtl/hex_display_sequencer.sv
// hex_display_sequencer
//   Time-shares one external combinational hex-to-7-segment decoder across
//   NUM_DIGITS displays. A result word is accepted by valid/ready handshake,
//   scanned one nibble per cycle through the decoder, and the captured segment
//   words are committed to the display all at once. Leading-zero suppression,
//   per-digit blanking and per-digit blinking are applied on top.
//
// Ports
//   clk             system clock
//   rst             synchronous, active-high reset
//   upd_valid       new display request
//   upd_ready       request can be accepted (idle and not in reset)
//   upd_value       nibble k drives digit k (digit 0 = rightmost)
//   upd_blank_mask  1 = force digit dark
//   upd_blink_mask  1 = digit blinks
//   dec_nibble      to shared decoder inputs (bit 3 = A = MSB)
//   dec_seg         from shared decoder, same cycle, active-low {g,f,e,d,c,b,a}
//   hex_out         digit k on [7k+6:7k], active-low, registered
//   busy            scan or commit in progress
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a request; dec_nibble holds last scanned nibble
//   SCAN   | drive nibble[idx] to decoder, capture segments into shadow[idx]
//   COMMIT | copy shadow (with blank/suppression) to visible, latch blink mask

module hex_display_sequencer #(
    parameter int NUM_DIGITS  = 4,
    parameter int BLINK_DIV   = 25000000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_value,
    input  logic [NUM_DIGITS-1:0]   upd_blank_mask,
    input  logic [NUM_DIGITS-1:0]   upd_blink_mask,
    output logic [3:0]              dec_nibble,
    input  logic [6:0]              dec_seg,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy
);

    localparam int VW    = 4 * NUM_DIGITS;
    localparam int SW    = 7 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [VW-1:0]     value_lat;
    logic [NUM_DIGITS-1:0] blank_lat;
    logic [NUM_DIGITS-1:0] blink_lat;
    logic [NUM_DIGITS-1:0] blink_vis;
    logic [SW-1:0]     shadow;
    logic [SW-1:0]     visible;
    logic [SW-1:0]     commit_word;
    logic [3:0]        nib_last;
    logic [3:0]        cur_nibble;
    logic [CNT_W-1:0]  blink_cnt;
    logic              blink_phase;
    logic              accept;

    assign accept = upd_valid && upd_ready;

    always_comb begin
        cur_nibble = value_lat[4*int'(idx) +: 4];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and FSM outputs
    always_comb begin
        state_nxt  = state;
        upd_ready  = 1'b0;
        busy       = 1'b0;
        dec_nibble = nib_last;
        case (state)
            IDLE: begin
                upd_ready = !rst;
                if (upd_valid && !rst) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy       = 1'b1;
                dec_nibble = cur_nibble;
                if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Commit word: walk from the most significant digit down so that
    // all_zero tells whether this digit and everything above it is zero.
    // Digit 0 is never suppressed so a zero value still shows "0".
    always_comb begin
        logic all_zero;
        all_zero    = 1'b1;
        commit_word = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (value_lat[4*k +: 4] == 4'h0);
            if (blank_lat[k] || ((LZ_SUPPRESS != 0) && (k > 0) && all_zero)) begin
                commit_word[7*k +: 7] = 7'h7F;
            end else begin
                commit_word[7*k +: 7] = shadow[7*k +: 7];
            end
        end
    end

    // Datapath, blink timer and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            value_lat   <= '0;
            blank_lat   <= '0;
            blink_lat   <= '0;
            blink_vis   <= '0;
            shadow      <= '0;
            visible     <= '1;
            nib_last    <= 4'h0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            hex_out     <= '1;
        end else begin
            if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end

            for (int k = 0; k < NUM_DIGITS; k++) begin
                hex_out[7*k +: 7] <= (blink_phase && blink_vis[k]) ? 7'h7F
                                                                  : visible[7*k +: 7];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        value_lat <= upd_value;
                        blank_lat <= upd_blank_mask;
                        blink_lat <= upd_blink_mask;
                        idx       <= '0;
                    end
                end
                SCAN: begin
                    shadow[7*int'(idx) +: 7] <= dec_seg;
                    nib_last                 <= cur_nibble;
                    idx                      <= idx + IDX_W'(1);
                end
                COMMIT: begin
                    visible   <= commit_word;
                    blink_vis <= blink_lat;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_sequencer.sv
module tb_hex_display_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_value;
    logic [3:0]  upd_blank_mask;
    logic [3:0]  upd_blink_mask;
    logic [3:0]  dec_nibble;
    logic [6:0]  dec_seg;
    logic [27:0] hex_out;
    logic        busy;

    localparam logic [27:0] DARK = 28'hFFFFFFF;
    localparam logic [27:0] ALL  = 28'hFFFFFFF;

    hex_display_sequencer #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .LZ_SUPPRESS(1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_value     (upd_value),
        .upd_blank_mask(upd_blank_mask),
        .upd_blink_mask(upd_blink_mask),
        .dec_nibble    (dec_nibble),
        .dec_seg       (dec_seg),
        .hex_out       (hex_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External shared decoder, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: seg_of = 7'h40;  4'h1: seg_of = 7'h79;
            4'h2: seg_of = 7'h24;  4'h3: seg_of = 7'h30;
            4'h4: seg_of = 7'h19;  4'h5: seg_of = 7'h12;
            4'h6: seg_of = 7'h02;  4'h7: seg_of = 7'h78;
            4'h8: seg_of = 7'h00;  4'h9: seg_of = 7'h10;
            4'hA: seg_of = 7'h08;  4'hB: seg_of = 7'h03;
            4'hC: seg_of = 7'h46;  4'hD: seg_of = 7'h21;
            4'hE: seg_of = 7'h06;  default: seg_of = 7'h0E;
        endcase
    endfunction

    assign dec_seg = seg_of(dec_nibble);

    int n_checks = 0;
    int n_fail   = 0;
    int pcnt     = 0;

    always @(posedge clk) pcnt <= pcnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: entry pushed at the negedge before the accepting posedge,
    // display due after six more posedges.
    typedef struct {
        logic [27:0] exp;
        logic [27:0] care;
        int          due;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;

    task automatic push_exp(input string name, input logic [27:0] exp, input logic [27:0] care);
        sb_t e;
        e.exp  = exp;
        e.care = care;
        e.due  = pcnt + 7;
        e.name = name;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && pcnt >= sb_q[0].due) begin
            mon_e = sb_q.pop_front();
            check(mon_e.name, {4'h0, hex_out & mon_e.care}, {4'h0, mon_e.exp & mon_e.care});
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (upd_ready === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_ready: ready never rose within 40 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain: %0d expected displays never checked", sb_q.size());
        sb_q.delete();
    endtask

    task automatic send(input string name, input logic [15:0] value, input logic [3:0] blank,
                        input logic [3:0] blink, input logic [27:0] exp, input logic [27:0] care);
        bit ok;
        upd_value      = value;
        upd_blank_mask = blank;
        upd_blink_mask = blink;
        upd_valid      = 1'b1;
        wait_ready(ok);
        if (!ok) begin
            upd_valid = 1'b0;
            return;
        end
        push_exp(name, exp, care);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) upd_valid = 1'b0;
            check("scan_nibble", {28'h0, dec_nibble}, {28'h0, value[4*i +: 4]});
            check("scan_busy", {31'h0, busy}, 32'h1);
        end
        @(negedge clk);
        check("commit_busy", {31'h0, busy}, 32'h1);
        check("commit_ready", {31'h0, upd_ready}, 32'h0);
        @(negedge clk);
        check("idle_ready", {31'h0, upd_ready}, 32'h1);
        check("idle_nibble_hold", {28'h0, dec_nibble}, {28'h0, value[15:12]});
    endtask

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [27:0] exp;
    } vec_t;

    vec_t vecs[10];

    logic [6:0] d0 [24];
    int last_t;
    int ntrans;
    bit ok;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h12AF, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0005, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[2] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h1000, 4'b0000, {7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h0300, 4'b0000, {7'h7F, 7'h30, 7'h40, 7'h40}};
        vecs[5] = '{16'h89CD, 4'b0100, {7'h00, 7'h7F, 7'h46, 7'h21}};
        vecs[6] = '{16'h0050, 4'b0010, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[7] = '{16'hFFFF, 4'b1111, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[8] = '{16'h0706, 4'b0000, {7'h7F, 7'h78, 7'h40, 7'h02}};
        vecs[9] = '{16'h3E4B, 4'b0000, {7'h30, 7'h06, 7'h19, 7'h03}};

        rst            = 1'b1;
        upd_valid      = 1'b0;
        upd_value      = 16'h0;
        upd_blank_mask = 4'h0;
        upd_blink_mask = 4'h0;

        // Reset
        @(negedge clk);
        check("rst_ready_low", {31'h0, upd_ready}, 32'h0);
        @(negedge clk);
        check("rst_hex_dark", {4'h0, hex_out}, {4'h0, DARK});
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_nibble", {28'h0, dec_nibble}, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'h0, upd_ready}, 32'h1);

        // Table-driven displays
        for (int v = 0; v < 10; v++) begin
            send($sformatf("vec%0d_hex", v), vecs[v].value, vecs[v].blank, 4'b0000,
                 vecs[v].exp, ALL);
            drain();
        end

        // Back-to-back with valid held
        upd_value      = 16'h12AF;
        upd_blank_mask = 4'h0;
        upd_blink_mask = 4'h0;
        upd_valid      = 1'b1;
        wait_ready(ok);
        if (ok) begin
            push_exp("b2b_first", {7'h79, 7'h24, 7'h08, 7'h0E}, ALL);
            @(negedge clk);
            upd_value = 16'h0005;
            check("b2b_ready_busy0", {31'h0, upd_ready}, 32'h0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("b2b_ready_busy", {31'h0, upd_ready}, 32'h0);
            end
            @(negedge clk);
            check("b2b_ready_again", {31'h0, upd_ready}, 32'h1);
            push_exp("b2b_second", {7'h7F, 7'h7F, 7'h7F, 7'h12}, ALL);
            @(negedge clk);
            upd_valid = 1'b0;
        end else begin
            upd_valid = 1'b0;
        end
        drain();

        // Blink on digit 0
        send("blink_setup", 16'h12AF, 4'b0000, 4'b0001, {7'h79, 7'h24, 7'h08, 7'h0E},
             {21'h1FFFFF, 7'h00});
        drain();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d0[i] = hex_out[6:0];
            check("blink_steady_hi", {11'h0, hex_out[27:7]}, {11'h0, 7'h79, 7'h24, 7'h08});
            check("blink_d0_value", {31'h0, (d0[i] == 7'h0E) || (d0[i] == 7'h7F)}, 32'h1);
        end
        last_t = -1;
        ntrans = 0;
        for (int i = 1; i < 24; i++) begin
            if (d0[i] != d0[i-1]) begin
                if (last_t >= 0) check("blink_half_period", i - last_t, 4);
                last_t = i;
                ntrans++;
            end
        end
        check("blink_toggle_count", {31'h0, ntrans >= 4}, 32'h1);

        // Reset during the second scan cycle
        upd_value      = 16'h89CD;
        upd_blank_mask = 4'h0;
        upd_blink_mask = 4'h0;
        upd_valid      = 1'b1;
        wait_ready(ok);
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_hex_dark", {4'h0, hex_out}, {4'h0, DARK});
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_ready", {31'h0, upd_ready}, 32'h0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", {31'h0, upd_ready}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_no_commit", {4'h0, hex_out}, {4'h0, DARK});
        end
        send("after_abort", 16'h3E4B, 4'b0000, 4'b0000, {7'h30, 7'h06, 7'h19, 7'h03}, ALL);
        drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("no_blink_steady", {4'h0, hex_out}, {4'h0, 7'h30, 7'h06, 7'h19, 7'h03});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
